// File: rtl/addsub_serial.sv
// Digit-serial unsigned adder/subtractor: DIGIT bits per cycle, LSB digit first, valid/ready on both sides.
// Define ADDSUB_OVF_EN to compute signed overflow on ovf; otherwise ovf is tied to 0.
module addsub_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             u,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("addsub_serial: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
    logic              u_q, u_d, c_q, c_d, chain_q, chain_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    int unsigned       base;
    logic [DIGIT-1:0]  a_k, b_k, dig_res;
    logic [DIGIT:0]    dig_full;
    logic              chain_nx, accept, last;

    assign accept = (state_q == StIdle) && in_valid;
    assign last   = (state_q == StRun) && (cnt_q == CntW'(N - 1));

    // Bit DIGIT of the (DIGIT+1)-bit result is the carry for add and the borrow for sub.
    always_comb begin
        base     = 32'(cnt_q) * DIGIT;
        a_k      = a_q[base +: DIGIT];
        b_k      = b_q[base +: DIGIT];
        if (u_q) begin
            dig_full = {1'b0, a_k} - {1'b0, b_k} - {{DIGIT{1'b0}}, chain_q};
        end else begin
            dig_full = {1'b0, a_k} + {1'b0, b_k} + {{DIGIT{1'b0}}, chain_q};
        end
        dig_res  = dig_full[DIGIT-1:0];
        chain_nx = dig_full[DIGIT];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        u_d     = u_q;
        s_d     = s_q;
        c_d     = c_q;
        chain_d = chain_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    u_d     = u;
                    s_d     = '0;
                    c_d     = 1'b0;
                    chain_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                s_d[base +: DIGIT] = dig_res;
                chain_d            = chain_nx;
                cnt_d              = cnt_q + CntW'(1);
                if (last) begin
                    c_d     = chain_nx;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            u_q     <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
            chain_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            u_q     <= u_d;
            s_q     <= s_d;
            c_q     <= c_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ADDSUB_OVF_EN
    logic ovf_q, ovf_d;

    // The last digit carries the result MSB, so overflow is known in the final RUN cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if (last) begin
            if (u_q) begin
                ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dig_res[DIGIT-1] != a_q[WIDTH-1]);
            end else begin
                ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (dig_res[DIGIT-1] != a_q[WIDTH-1]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign s         = s_q;
    assign c         = c_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: three instances (DIGIT = 4, 1, 16) share stimulus and are
// checked against an arithmetic reference model.
module tb_addsub_serial;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         u = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic [2:0]   in_rdy, out_vld, c_v, ovf_v;
    logic [W-1:0] s_v [3];

    int n_cmp = 0;
    int n_err = 0;
    int lat_exp [3] = '{4, 16, 1};

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(W), .DIGIT(4)) u_dut_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[0]), .a(a), .b(b), .u(u),
        .out_valid(out_vld[0]), .out_ready(out_ready), .s(s_v[0]), .c(c_v[0]), .ovf(ovf_v[0])
    );
    addsub_serial #(.WIDTH(W), .DIGIT(1)) u_dut_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[1]), .a(a), .b(b), .u(u),
        .out_valid(out_vld[1]), .out_ready(out_ready), .s(s_v[1]), .c(c_v[1]), .ovf(ovf_v[1])
    );
    addsub_serial #(.WIDTH(W), .DIGIT(16)) u_dut_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_rdy[2]), .a(a), .b(b), .u(u),
        .out_valid(out_vld[2]), .out_ready(out_ready), .s(s_v[2]), .c(c_v[2]), .ovf(ovf_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mu,
                         output logic [W-1:0] es, output logic ec, output logic eov);
        int full, sres;
        if (!mu) begin
            full = int'(ma) + int'(mb);
            ec   = (full > 65535);
            sres = int'($signed(ma)) + int'($signed(mb));
        end else begin
            full = int'(ma) - int'(mb);
            ec   = (ma < mb);
            sres = int'($signed(ma)) - int'($signed(mb));
        end
        es = 16'(full);
`ifdef ADDSUB_OVF_EN
        eov = (sres > 32767) || (sres < -32768);
`else
        eov = 1'b0;
`endif
    endtask

    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ou,
                          input bit bp);
        logic [W-1:0] es;
        logic         ec, eov;
        int           lat [3];
        int           cyc;
        model(oa, ob, ou, es, ec, eov);
        check("in_ready_before_op", 32'(in_rdy), 32'h7);
        a = oa; b = ob; u = ou; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); u = 1'($urandom);
        lat = '{0, 0, 0};
        cyc = 0;
        while (out_vld != 3'b111 && cyc < 40) begin
            tick();
            cyc++;
            for (int i = 0; i < 3; i++) if (out_vld[i] && lat[i] == 0) lat[i] = cyc;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("latency[%0d]", i), 32'(lat[i]), 32'(lat_exp[i]));
            check($sformatf("s[%0d] %h%s%h", i, oa, ou ? "-" : "+", ob), 32'(s_v[i]), 32'(es));
            check($sformatf("c[%0d] %h%s%h", i, oa, ou ? "-" : "+", ob), 32'(c_v[i]), 32'(ec));
            check($sformatf("ovf[%0d] %h%s%h", i, oa, ou ? "-" : "+", ob), 32'(ovf_v[i]),
                  32'(eov));
        end
        if (bp) begin
            in_valid = 1'b1;
            for (int k = 0; k < 5; k++) begin
                a = W'($urandom); b = W'($urandom); u = 1'($urandom);
                tick();
                check("bp_in_ready", 32'(in_rdy), 32'h0);
                check("bp_out_valid", 32'(out_vld), 32'h7);
                check("bp_s_hold", 32'(s_v[0]), 32'(es));
                check("bp_c_hold", 32'(c_v), {29'd0, {3{ec}}});
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("idle_in_ready", 32'(in_rdy), 32'h7);
        check("idle_out_valid", 32'(out_vld), 32'h0);
    endtask

    initial begin
        logic [2:0] seen_vld;
        logic [W-1:0] ra, rb;
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(in_rdy), 32'h7);
        check("rst_out_valid", 32'(out_vld), 32'h0);
        check("rst_c", 32'(c_v), 32'h0);
        check("rst_ovf", 32'(ovf_v), 32'h0);
        for (int i = 0; i < 3; i++) check("rst_s", 32'(s_v[i]), 32'h0);
        rst = 1'b0;
        tick();

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        run_op(16'h1234, 16'h1234, 1'b1, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0000, 16'hFFFF, 1'b1, 1'b0);

        for (int n = 0; n < 30; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (n % 7 == 3) rb = ra;
            run_op(ra, rb, 1'($urandom), (n % 10 == 5));
        end

        // Abort during the second RUN cycle; nothing may be presented afterwards.
        a = 16'hABCD; b = 16'h9876; u = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 32'(in_rdy), 32'h7);
        check("abort_out_valid", 32'(out_vld), 32'h0);
        check("abort_c", 32'(c_v), 32'h0);
        check("abort_ovf", 32'(ovf_v), 32'h0);
        for (int i = 0; i < 3; i++) check("abort_s", 32'(s_v[i]), 32'h0);
        seen_vld = 3'b000;
        for (int k = 0; k < 20; k++) begin
            tick();
            seen_vld = seen_vld | out_vld;
        end
        check("abort_no_result", 32'(seen_vld), 32'h0);

        run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
